spectrum_reader: RTL



---
 rtl/spectrum_reader.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/spectrum_reader.sv
// rtl/spectrum_reader.sv - scans the histogram RAM and streams its bins as a framed byte stream.
// Optional trailing 8-bit checksum byte is built when SPECTRUM_CSUM_EN is defined.
module spectrum_reader #(
    parameter int N      = 16,
    parameter int ADDR_W = 10,
    parameter int BINS   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [N-1:0]      rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int                NB        = N / 8;
    localparam logic [2:0]        LAST_BYTE = 3'(NB - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BINS - 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        RD_WAIT,
        SEND,
`ifdef SPECTRUM_CSUM_EN
        CSUM,
`endif
        FIN
    } state_t;

    state_t         state, state_n;
    logic [N-1:0]   shreg;
    logic [2:0]     byte_idx;
    logic           wait_cnt;
    logic           hs;
    logic           last_byte;
`ifdef SPECTRUM_CSUM_EN
    logic [7:0]     csum;
`endif

    assign hs        = tx_valid && tx_ready;
    assign last_byte = (byte_idx == LAST_BYTE);

    // Outputs are decoded from registered state only, so tx_valid never sees tx_ready.
    always_comb begin
        state_n  = state;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        busy     = (state != IDLE) && (state != FIN);
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_n = HDR0;
            end
            HDR0: begin
                tx_valid = 1'b1;
                tx_data  = 8'hA5;
                if (tx_ready) state_n = HDR1;
            end
            HDR1: begin
                tx_valid = 1'b1;
                tx_data  = 8'h5A;
                if (tx_ready) state_n = RD_WAIT;
            end
            RD_WAIT: begin
                if (wait_cnt) state_n = SEND;
            end
            SEND: begin
                tx_valid = 1'b1;
                tx_data  = shreg[N-1 -: 8];
                if (tx_ready && last_byte) begin
                    if (rd_addr == LAST_ADDR) begin
`ifdef SPECTRUM_CSUM_EN
                        state_n = CSUM;
`else
                        state_n = FIN;
`endif
                    end else begin
                        state_n = RD_WAIT;
                    end
                end
            end
`ifdef SPECTRUM_CSUM_EN
            CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum;
                if (tx_ready) state_n = FIN;
            end
`endif
            FIN: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rd_addr  <= '0;
            shreg    <= '0;
            byte_idx <= '0;
            wait_cnt <= 1'b0;
`ifdef SPECTRUM_CSUM_EN
            csum     <= 8'h00;
`endif
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (start) begin
                        rd_addr  <= '0;
                        byte_idx <= '0;
                        wait_cnt <= 1'b0;
`ifdef SPECTRUM_CSUM_EN
                        csum     <= 8'h00;
`endif
                    end
                end
                // First wait cycle lets the RAM sample rd_addr, second captures its output.
                RD_WAIT: begin
                    wait_cnt <= ~wait_cnt;
                    if (wait_cnt) begin
                        shreg    <= rd_data;
                        byte_idx <= '0;
                    end
                end
                SEND: begin
                    if (hs) begin
                        shreg    <= shreg << 8;
                        byte_idx <= byte_idx + 3'd1;
`ifdef SPECTRUM_CSUM_EN
                        csum     <= csum + tx_data;
`endif
                        if (last_byte) begin
                            byte_idx <= '0;
                            if (rd_addr != LAST_ADDR) rd_addr <= rd_addr + ADDR_W'(1);
                        end
                    end
                end
                FIN: begin
                    rd_addr <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
